// File: rtl/summator_reg_if.sv
// Operand/sum bundle for the registered adder. The master side supplies the
// two unsigned operands and observes the registered sum; the slave side is
// the adder itself.
interface summator_reg_if #(
  parameter int reglength = 3
);
  logic [reglength-1:0] r1;
  logic [reglength-1:0] r2;
  logic [reglength:0]   summa;

  modport master (output r1, output r2, input summa);
  modport slave  (input r1, input r2, output summa);
endinterface

// File: rtl/summator_reg.sv
// Registered unsigned adder: operands are captured on one edge, their sum is
// registered on the next, so a pair sampled at edge N shows on summa after
// edge N+1. Reset preloads the operand registers with r1val/r2val (truncated
// to reglength bits) and the sum register with their full-width sum, so a
// known value is present on summa for as long as reset is held.
module summator_reg #(
  parameter int          reglength = 3,
  parameter int unsigned r1val     = 0,
  parameter int unsigned r2val     = 0
) (
  input  logic           clk,
  input  logic           rst,
  summator_reg_if.slave  bus
);

  localparam logic [reglength-1:0] A_RST = r1val[reglength-1:0];
  localparam logic [reglength-1:0] B_RST = r2val[reglength-1:0];
  localparam logic [reglength:0]   S_RST = {1'b0, A_RST} + {1'b0, B_RST};

  logic [reglength-1:0] a_p0;
  logic [reglength-1:0] b_p0;
  logic [reglength:0]   s_p1;

  logic [reglength:0]   carry;
  logic [reglength-1:0] sum_bits;

  // Stage p0: capture operands every cycle; no enable, the pipe always moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0 <= A_RST;
      b_p0 <= B_RST;
    end else begin
      a_p0 <= bus.r1;
      b_p0 <= bus.r2;
    end
  end

  // Ripple-carry chain of full-adder cells over the captured operands.
  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < reglength; i++) begin : g_fa
      assign sum_bits[i]  = a_p0[i] ^ b_p0[i] ^ carry[i];
      assign carry[i+1]   = (a_p0[i] & b_p0[i]) | (carry[i] & (a_p0[i] ^ b_p0[i]));
    end
  endgenerate

  // Stage p1: register the sum; the final carry lands in the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p1 <= S_RST;
    end else begin
      s_p1 <= {carry[reglength], sum_bits};
    end
  end

  assign bus.summa = s_p1;

endmodule

// File: tb/tb_summator_reg.sv
// Bench for summator_reg: three instances with different reset constants
// share clock, reset and operands. Each is compared with a delay-line model
// of the sum of the operand pairs accepted since the last reset.
module tb_summator_reg;

  localparam int RL = 3;
  localparam int ND = 3;

  logic clk;
  logic rst;
  logic [RL-1:0] r1;
  logic [RL-1:0] r2;
  logic [RL:0]   summa [ND];

  int n_checks = 0;
  int n_errors = 0;

  // Reset sums: 2+3, 1+1, (9 truncated to 1)+0.
  int unsigned rsum [ND] = '{5, 2, 1};
  int unsigned mq   [ND][$];
  int unsigned mexp [ND];

  summator_reg_if #(.reglength(RL)) bus0 ();
  summator_reg_if #(.reglength(RL)) bus1 ();
  summator_reg_if #(.reglength(RL)) bus2 ();

  assign bus0.r1 = r1;  assign bus0.r2 = r2;  assign summa[0] = bus0.summa;
  assign bus1.r1 = r1;  assign bus1.r2 = r2;  assign summa[1] = bus1.summa;
  assign bus2.r1 = r1;  assign bus2.r2 = r2;  assign summa[2] = bus2.summa;

  summator_reg #(.reglength(RL), .r1val(2), .r2val(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  summator_reg #(.reglength(RL), .r1val(1), .r2val(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  summator_reg #(.reglength(RL), .r1val(9), .r2val(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Model of reset: pending pipeline content is discarded, output is the reset sum.
  task automatic reset_model();
    for (int d = 0; d < ND; d++) begin
      mq[d].delete();
      mq[d].push_back(rsum[d]);
      mexp[d] = rsum[d];
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("%s[%0d]", tag, d), int'(summa[d]), mexp[d]);
  endtask

  // One rising edge: the model accepts the current pair unless reset holds,
  // then every output is compared shortly after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        mq[d].push_back(int'(r1) + int'(r2));
        mexp[d] = mq[d].pop_front();
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input int unsigned a, input int unsigned b);
    @(negedge clk);
    r1 = RL'(a);
    r2 = RL'(b);
  endtask

  initial begin
    r1  = '0;
    r2  = '0;
    rst = 1'b1;
    reset_model();
    #1;
    // Reset values are present before any clock edge.
    check_eq("rst_async0", int'(summa[0]), 5);
    check_eq("rst_async1", int'(summa[1]), 2);
    check_eq("rst_trunc2", int'(summa[2]), 1);
    tick("rst_hold");
    tick("rst_hold");

    // Release; steady 1+1 then a change to 5+2 shows the two-edge latency.
    drive(1, 1);
    rst = 1'b0;
    tick("post_rst1");
    check_eq("post_rst1_still5", int'(summa[0]), 5);
    tick("steady11");
    drive(1, 1);
    tick("steady11");
    check_eq("steady_is2", int'(summa[0]), 2);
    drive(5, 2);
    tick("lat_n1");
    check_eq("lat_n1_is2", int'(summa[0]), 2);
    tick("lat_n2");
    check_eq("lat_n2_is7", int'(summa[0]), 7);

    // Maximum operands: carry-out set.
    drive(7, 7);
    tick("max");
    tick("max");
    check_eq("max_is14", int'(summa[1]), 14);

    // Streaming new pairs every cycle, no bubbles.
    drive(0, 0); tick("stream");
    drive(3, 4); tick("stream");
    check_eq("stream_0", int'(summa[0]), 0);
    drive(6, 1); tick("stream");
    check_eq("stream_7a", int'(summa[0]), 7);
    drive(7, 0); tick("stream");
    check_eq("stream_7b", int'(summa[0]), 7);
    tick("stream");
    check_eq("stream_7c", int'(summa[0]), 7);

    // Mid-run asynchronous reset during 7+7 streaming.
    drive(7, 7); tick("pre_mrst");
    tick("pre_mrst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    check_all("mid_rst_async");
    check_eq("mid_rst_dut1_is2", int'(summa[1]), 2);
    tick("mid_rst_hold");
    drive(4, 4);
    rst = 1'b0;
    tick("mid_rst_e1");
    tick("mid_rst_e2");
    check_eq("mid_rst_8", int'(summa[1]), 8);

    // Randomized streaming with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        check_all("rnd_arst");
        if ($urandom_range(0, 1) == 0) begin
          tick("rnd_rst_edge");
          @(negedge clk);
        end
        rst = 1'b0;
      end
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/summator_reg.md
Name: summator_reg

Overview:
- Registered unsigned adder.
- Captures two reglength-bit operands each clock and presents their (reglength+1)-bit sum one clock later.
- Reset preloads the operand registers with parameter constants, so a known sum is available straight out of reset.
- Used as a small arithmetic leaf block in datapath/lab designs.

Parameters:
- reglength, 3, operand width in bits (>=1); sum is reglength+1 bits.
- r1val, 0, reset value of operand register A; truncated to low reglength bits.
- r2val, 0, reset value of operand register B; truncated to low reglength bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- r1  input  reglength  operand 1, unsigned.
- r2  input  reglength  operand 2, unsigned.
- summa  output  reglength+1  registered unsigned sum; MSB is carry-out.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Internal state:
  - operand register A[reglength-1:0]
  - operand register B[reglength-1:0]
  - sum register S[reglength:0], driving summa directly.
- Reset:
  - While rst=1, independent of clk: A=r1val[reglength-1:0], B=r2val[reglength-1:0], S=A_rst+B_rst (reglength+1 bits, no truncation).
  - Example: reglength=3, r1val=2, r2val=3 -> summa=5 during and after reset.
- Reset assertion takes effect immediately (asynchronous). Deassertion is sampled at the next rising clk edge; no capture occurs on the edge where rst is still high.
- Normal operation, each rising edge with rst=0:
  - A<=r1, B<=r2.
  - S<=A+B, using the A and B values from before the edge.
- Latency: r1/r2 sampled at edge N appear on summa after edge N+1 (2-edge latency, fully pipelined, new operands accepted every cycle).
- Arithmetic:
  - Unsigned.
  - Sum computed by an explicit ripple-carry chain of reglength full-adder cells, built with generate. Carry-in of the LSB cell is 0.
  - Final carry becomes summa[reglength].
  - No overflow is possible; the maximum (2^reglength-1)*2 fits in reglength+1 bits.
- No handshake, no enable: the pipeline always advances.
- Reset mid-operation: in-flight operands are discarded; summa returns to r1val+r2val asynchronously. The first post-reset sum from new inputs appears two edges after deassertion.
- summa is glitch-free: driven only from the S flop.
- Parameters r1val/r2val wider than reglength: silently truncated, no error.
- X/Z on r1/r2 propagates; no sanitising.

Test Plan:
- Reset value: reglength=3, r1val=2, r2val=3, rst pulse -> summa=5 immediately, without waiting for a clock edge; holds until 2 edges after the first new capture.
- Max operands: r1=7, r2=7 held -> after 2 rising edges summa=14 (4'b1110), carry bit set.
- Latency: steady r1=1, r2=1 (summa=2), then change to r1=5, r2=2 just after edge N -> summa=2 after edge N+1, 7 after edge N+2.
- Streaming: new pairs each cycle (0+0, 3+4, 6+1, 7+0) -> summa sequence 0, 7, 7, 7 with exactly 2-edge offset, no bubbles.
- Mid-run reset: during streaming of 7+7, assert rst asynchronously between edges with r1val=1, r2val=1 -> summa=2 at once. After release, inputs 4+4 -> summa=8 two edges after first post-reset edge.
- Truncation: r1val=9, r2val=0, reglength=3 -> reset summa=1.
